// File: rtl/mdu_result_stage.sv
// mdu_result_stage: result fix-up and output buffer behind the iterative MDU.
// Captures raw magnitudes from the MDU and applies sign correction.
// Selects the RISC-V M-extension result, including the divide-by-zero and
// signed-overflow cases.
// Holds finished results in a DEPTH-entry FIFO with a valid/ready handshake
// toward writeback.
// Optional: define MDU_RESULT_BYPASS_EN for a zero-latency path when idle.
module mdu_result_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_hi,
    input  logic [XLEN-1:0] in_lo,
    input  logic            in_neg_q,
    input  logic            in_neg_r,
    input  logic            in_div0,
    input  logic            in_ovf,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [4:0]      in_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic [2:0]      wb_count
);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    // Pointer width sized so the slot array index matches exactly.
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PW;

    logic [XLEN-1:0]   sel_data;
    logic              bypass;
    logic              accept;
    logic              s1_load;
    logic              s1_adv;
    logic              fifo_pop;
    logic              fifo_empty;

    logic              s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]   s1_data_q,  s1_data_d;
    logic [4:0]        s1_rd_q,    s1_rd_d;
    logic [XLEN-1:0]   mem_data_q [SLOTS];
    logic [XLEN-1:0]   mem_data_d [SLOTS];
    logic [4:0]        mem_rd_q   [SLOTS];
    logic [4:0]        mem_rd_d   [SLOTS];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q,  count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Sign fix-up and M-extension result selection from raw magnitudes.
    always_comb begin
        logic [63:0] prod_mag;
        logic [63:0] prod;
        prod_mag = {in_hi, in_lo};
        prod     = in_neg_q ? (64'd0 - prod_mag) : prod_mag;
        sel_data = '0;
        case (op_e'(in_funct3))
            OP_MUL:                        sel_data = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  sel_data = prod[63:32];
            OP_DIV:  sel_data = in_div0 ? '1 :
                                in_ovf  ? {1'b1, {(XLEN-1){1'b0}}} :
                                in_neg_q ? -in_lo : in_lo;
            OP_DIVU: sel_data = in_div0 ? '1 : (in_neg_q ? -in_lo : in_lo);
            OP_REM:  sel_data = in_div0 ? in_rs1 :
                                in_ovf  ? '0 :
                                in_neg_r ? -in_hi : in_hi;
            OP_REMU: sel_data = in_div0 ? in_rs1 : (in_neg_r ? -in_hi : in_hi);
            default: sel_data = '0;
        endcase
    end

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_pop   = !fifo_empty && wb_ready;
    assign s1_adv     = s1_valid_q && ((count_q < 3'(DEPTH)) || fifo_pop);
    assign in_ready   = !s1_valid_q || s1_adv;
    assign accept     = in_valid && in_ready;

`ifdef MDU_RESULT_BYPASS_EN
    // Idle pipeline with a ready consumer: hand the result straight out.
    assign bypass = in_valid && !s1_valid_q && fifo_empty && wb_ready;
`else
    assign bypass = 1'b0;
`endif

    assign s1_load  = accept && !bypass;
    assign wb_valid = !fifo_empty || bypass;
    assign wb_data  = bypass ? sel_data : mem_data_q[rd_ptr_q];
    assign wb_rd    = bypass ? in_rd    : mem_rd_q[rd_ptr_q];
    assign wb_count = count_q;

    // Next-state for the fix-up register and the result FIFO.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_rd_d    = s1_rd_q;
        mem_data_d = mem_data_q;
        mem_rd_d   = mem_rd_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_data_d  = sel_data;
            s1_rd_d    = in_rd;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            mem_data_d[wr_ptr_q] = s1_data_q;
            mem_rd_d[wr_ptr_q]   = s1_rd_q;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({s1_adv, fifo_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every held result at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_rd_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                mem_data_q[i] <= '0;
                mem_rd_q[i]   <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_rd_q    <= s1_rd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_data_q <= mem_data_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

endmodule

// File: tb/tb_mdu_result_stage.sv
// Scoreboard bench for mdu_result_stage (DEPTH=2): directed vectors push
// expected results on accept; a monitor pops and compares on each wb transfer.
module tb_mdu_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_hi = '0, in_lo = '0, in_rs1 = '0;
    logic        in_neg_q = 1'b0, in_neg_r = 1'b0, in_div0 = 1'b0, in_ovf = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_count;

    mdu_result_stage #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_hi(in_hi), .in_lo(in_lo), .in_neg_q(in_neg_q), .in_neg_r(in_neg_r),
        .in_div0(in_div0), .in_ovf(in_ovf), .in_rs1(in_rs1), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

`ifdef MDU_RESULT_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        pending;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_pop_cyc = 0;
    int          acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Monitor: compare every writeback transfer against the scoreboard head.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb_rd", {27'd0, wb_rd}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic set_op(input logic [2:0] f3, input logic [31:0] hi, input logic [31:0] lo,
                          input logic nq, input logic nr, input logic d0, input logic ov,
                          input logic [31:0] rs1, input logic [4:0] rd, input logic [31:0] expd);
        in_valid = 1'b1; in_funct3 = f3; in_hi = hi; in_lo = lo;
        in_neg_q = nq; in_neg_r = nr; in_div0 = d0; in_ovf = ov;
        in_rs1 = rs1; in_rd = rd;
        pending.data = expd;
        pending.rd   = rd;
    endtask

    // Hold the pending op until accepted; an expired budget counts as a failure.
    task automatic wait_accept(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(pending);
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] hi, input logic [31:0] lo,
                         input logic nq, input logic nr, input logic d0, input logic ov,
                         input logic [31:0] rs1, input logic [4:0] rd, input logic [31:0] expd);
        set_op(f3, hi, lo, nq, nr, d0, ov, rs1, rd, expd);
        wait_accept(10);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0 && wb_count == 3'd0) done = 1;
        end
        check("drain", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_count", {29'd0, wb_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: MUL of negated 64-bit magnitude, and latency from accept
        wb_ready = 1'b1;
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0, 0, 0, 5'd1, 32'h0000_0002);
        repeat (4) @(posedge clk); #1;
        check("latency_t1", 32'(last_pop_cyc - acc_cyc), 32'(LAT));

        // 2: high halves, back to back
        issue(3'b001, 32'h0, 32'h1, 1, 0, 0, 0, 0, 5'd2, 32'hFFFF_FFFF);
        issue(3'b011, 32'h0, 32'h1, 0, 0, 0, 0, 0, 5'd3, 32'h0000_0000);
        issue(3'b000, 32'h0, 32'h0000_0007, 0, 0, 0, 0, 0, 5'd4, 32'h0000_0007);

        // 3: divide special and normal cases
        issue(3'b100, 32'h0, 32'h0000_0003, 0, 0, 1, 0, 0, 5'd5, 32'hFFFF_FFFF);
        issue(3'b110, 32'h9, 32'h0, 0, 0, 1, 0, 32'h1234_5678, 5'd6, 32'h1234_5678);
        issue(3'b100, 32'h0, 32'h0000_0001, 0, 0, 0, 1, 32'h8000_0000, 5'd7, 32'h8000_0000);
        issue(3'b110, 32'h7, 32'h0, 0, 1, 0, 1, 32'h8000_0000, 5'd8, 32'h0000_0000);
        issue(3'b101, 32'h0, 32'h0000_0005, 0, 0, 0, 1, 0, 5'd9, 32'h0000_0005);
        issue(3'b100, 32'h0, 32'h0000_0002, 0, 0, 1, 1, 0, 5'd10, 32'hFFFF_FFFF);
        issue(3'b100, 32'h0, 32'h0000_0007, 1, 0, 0, 0, 0, 5'd11, 32'hFFFF_FFF9);
        issue(3'b110, 32'h3, 32'h0, 0, 1, 0, 0, 0, 5'd12, 32'hFFFF_FFFD);
        issue(3'b111, 32'h3, 32'h0, 0, 0, 0, 1, 0, 5'd13, 32'h0000_0003);
        issue(3'b111, 32'h3, 32'h0, 0, 0, 1, 0, 32'hCAFE_0001, 5'd14, 32'hCAFE_0001);
        drain();

        // 4: backpressure with writeback stalled
        wb_ready = 1'b0;
        for (int r = 1; r <= 3; r++)
            issue(3'b000, 32'h0, 32'h100 + r, 0, 0, 0, 0, 0, 5'(r), 32'h100 + r);
        set_op(3'b000, 32'h0, 32'h104, 0, 0, 0, 0, 0, 5'd4, 32'h104);
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_wb_count", {29'd0, wb_count}, 32'd2);
        @(posedge clk); #1;
        wb_ready = 1'b1;
        wait_accept(10);
        drain();

        // 5: full FIFO with simultaneous push and pop
        wb_ready = 1'b0;
        for (int r = 0; r < 3; r++)
            issue(3'b000, 32'h0, 32'h200 + r, 0, 0, 0, 0, 0, 5'(5 + r), 32'h200 + r);
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_op(3'b101, 32'h0, 32'h300 + i, 0, 0, 0, 0, 0, 5'(8 + i), 32'h300 + i);
            @(negedge clk);
            check("full_in_ready", {31'd0, in_ready}, 32'd1);
            check("full_wb_count", {29'd0, wb_count}, 32'd2);
            exp_q.push_back(pending);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // 6: reset with results queued, then latency after release
        wb_ready = 1'b0;
        issue(3'b000, 32'h0, 32'h400, 0, 0, 0, 0, 0, 5'd20, 32'h400);
        issue(3'b000, 32'h0, 32'h401, 0, 0, 0, 0, 0, 5'd21, 32'h401);
        repeat (2) @(posedge clk); #1;
        check("pre_rst_count", {29'd0, wb_count}, 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mid_rst_wb_count", {29'd0, wb_count}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        wb_ready = 1'b1;
        issue(3'b010, 32'h0000_00AB, 32'h0, 0, 0, 0, 0, 0, 5'd22, 32'h0000_00AB);
        repeat (4) @(posedge clk); #1;
        check("latency_after_rst", 32'(last_pop_cyc - acc_cyc), 32'(LAT));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
